// File: rtl/spram_fifo_if.sv
// Streaming handshake bundle for spram_fifo.
//   in_valid/in_ready/in_data    : push stream into the FIFO
//   out_valid/out_ready/out_data : show-ahead pop stream out of the FIFO
// master: the user of the FIFO (drives pushes, accepts pops)
// slave : the FIFO itself
interface spram_fifo_if #(
    parameter int DW = 8
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/spram.sv
// Generic synchronous single-port RAM.
//   clk  : clock, rising edge
//   rst  : synchronous active-high clear of the read register
//   ce   : chip enable, we : write enable, oe : output (read) enable
//   addr : address, di : write data
//   doq  : read data, valid the cycle after a read access
module spram #(
    parameter int aw = 10,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          we,
    input  logic          oe,
    input  logic [aw-1:0] addr,
    input  logic [dw-1:0] di,
    output logic [dw-1:0] doq
);
    logic [dw-1:0] mem [1 << aw];

    always_ff @(posedge clk) begin
        if (ce && we) begin
            mem[addr] <= di;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            doq <= '0;
        end else if (ce && oe && !we) begin
            doq <= mem[addr];
        end
    end
endmodule

// File: rtl/spram_fifo_obuf.sv
// Two-entry show-ahead output buffer for spram_fifo.
//   clk, rst_n : clock / asynchronous active-low reset
//   clr        : synchronous clear (empties the buffer)
//   push       : append push_data at the tail
//   pop        : drop the head entry (only when count != 0)
//   count      : number of entries held, 0..2
//   head       : oldest entry, meaningful while count != 0
module spram_fifo_obuf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    count,
    output logic [DW-1:0] head
);
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;

    // e0 is always the head; entries shift down on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            e0    <= '0;
            e1    <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        e0 <= push_data;
                    end else begin
                        e1 <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        e0 <= e1;
                        e1 <= push_data;
                    end else begin
                        e0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = e0;
endmodule

// File: rtl/spram_fifo.sv
// Byte FIFO controller owning the single port of an external spram.
//   clk, rst_n : clock / asynchronous active-low reset
//   flush      : synchronous clear of all contents (last_grant kept)
//   s          : push/pop stream bundle (slave side)
//   level      : total entries held (RAM + in-flight read + output buffer)
//   ram_*      : port of the external single-port RAM
// One RAM access per cycle; write and read alternate when both pend.
module spram_fifo #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    spram_fifo_if.slave   s,
    output logic [AW:0]   level,
    output logic          ram_ce,
    output logic          ram_we,
    output logic          ram_oe,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do
);
    localparam int unsigned DEPTH_I = 1 << AW;
    localparam logic [AW:0] DEPTH   = DEPTH_I[AW:0];

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_e;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic          inflight;
    grant_e        last_grant;

    logic [1:0]    ob_cnt;
    logic [DW-1:0] ob_head;

    logic          active;
    logic          full;
    logic          out_valid_i;
    logic          pop;
    logic          capture;
    logic [2:0]    committed;
    logic          wr_req;
    logic          rd_req;
    logic          wr_gnt;
    logic          rd_gnt;
    logic [AW:0]   ram_cnt_nxt;
    logic [1:0]    ob_cnt_nxt;
    logic [AW:0]   level_nxt;

    always_comb begin
        active      = rst_n && !flush;
        full        = (ram_cnt == DEPTH);
        out_valid_i = active && (ob_cnt != 2'd0);
        pop         = out_valid_i && s.out_ready;
        capture     = active && inflight;
        // Output-side slots already spoken for after this cycle's pop.
        committed   = {1'b0, ob_cnt} + {2'b0, inflight} - {2'b0, pop};
        wr_req      = s.in_valid && !full;
        rd_req      = (ram_cnt != '0) && (committed < 3'd2);
        wr_gnt      = active && wr_req && (!rd_req || last_grant == GRANT_RD);
        rd_gnt      = active && rd_req && (!wr_req || last_grant == GRANT_WR);

        s.in_ready  = active && !full && !(rd_req && last_grant == GRANT_WR);
        s.out_valid = out_valid_i;
        s.out_data  = ob_head;

        ram_ce      = wr_gnt || rd_gnt;
        ram_we      = wr_gnt;
        ram_oe      = rd_gnt;
        ram_addr    = rd_gnt ? rd_ptr : wr_ptr;
        ram_di      = s.in_data;

        ram_cnt_nxt = ram_cnt + (AW+1)'(wr_gnt) - (AW+1)'(rd_gnt);
        ob_cnt_nxt  = ob_cnt + 2'(capture) - 2'(pop);
        level_nxt   = ram_cnt_nxt + (AW+1)'(rd_gnt) + (AW+1)'(ob_cnt_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            inflight   <= 1'b0;
            last_grant <= GRANT_RD;
            level      <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            inflight   <= 1'b0;
            level      <= '0;
        end else begin
            if (wr_gnt) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_gnt) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_gnt) begin
                last_grant <= GRANT_WR;
            end else if (rd_gnt) begin
                last_grant <= GRANT_RD;
            end
            ram_cnt  <= ram_cnt_nxt;
            inflight <= rd_gnt;
            level    <= level_nxt;
        end
    end

    // A read in flight during flush is dropped: clr wins over push.
    spram_fifo_obuf #(.DW(DW)) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (capture),
        .push_data (ram_do),
        .pop       (pop),
        .count     (ob_cnt),
        .head      (ob_head)
    );
endmodule

// File: tb/tb_spram_fifo.sv
module tb_spram_fifo;
    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [AW:0]   level;
    logic          ram_ce, ram_we, ram_oe;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di, ram_do;

    spram_fifo_if #(.DW(DW)) bus ();

    spram_fifo #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .s        (bus),
        .level    (level),
        .ram_ce   (ram_ce),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe),
        .ram_addr (ram_addr),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    spram #(.aw(AW), .dw(DW)) u_ram (
        .clk  (clk),
        .rst  (1'b0),
        .ce   (ram_ce),
        .we   (ram_we),
        .oe   (ram_oe),
        .addr (ram_addr),
        .di   (ram_di),
        .doq  (ram_do)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [DW-1:0] q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples 1 time unit before each rising edge.
    // Reference: FIFO contents = accepted pushes minus pops; flush/reset empty it.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                q.delete();
            end else begin
                check("level", 32'(level), 32'(q.size()));
                if (bus.out_valid && bus.out_ready) begin
                    pops++;
                    check("pop_nonempty", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        check("out_data", 32'(bus.out_data), 32'(q.pop_front()));
                    end
                end
                if (flush) begin
                    q.delete();
                end else if (bus.in_valid && bus.in_ready) begin
                    q.push_back(bus.in_data);
                end
            end
        end
    end

    // One clock cycle of stimulus; returns at the sampling point.
    task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        #4;
    endtask

    task automatic drain();
        int k = 0;
        while (level != 0 && k < 100) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            k++;
        end
        check("drained", 32'(level), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic push_n(input int cnt, input logic ordy, input logic [DW-1:0] base);
        int n = 0;
        int k = 0;
        while (n < cnt && k < 200) begin
            cyc(1'b1, base + DW'(n), ordy, 1'b0);
            if (bus.in_valid && bus.in_ready) n++;
            k++;
        end
        check("push_n_count", 32'(n), 32'(cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, same, pop0;
        logic prev_we, have_prev, got;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state (in_valid high to show in_ready and RAM stay idle)
        @(negedge clk);
        bus.in_valid = 1'b1;
        #4;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ram_ce", 32'(ram_ce), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Latency: push at cycle 0, out_valid at cycle 3
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        check("lat_in_ready", 32'(bus.in_ready), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("lat_c1_valid", 32'(bus.out_valid), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("lat_c2_valid", 32'(bus.out_valid), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("lat_c3_valid", 32'(bus.out_valid), 32'd1);
        check("lat_c3_data", 32'(bus.out_data), 32'hA5);
        check("lat_c3_level", 32'(level), 32'd1);
        drain();

        // Back-to-back stream with out_ready=1; RAM accesses must alternate
        n = 0; k = 0; same = 0; have_prev = 1'b0; prev_we = 1'b0;
        pop0 = pops;
        while (n < 16 && k < 100) begin
            cyc(1'b1, DW'(n), 1'b1, 1'b0);
            if (ram_ce) begin
                if (have_prev && ram_we == prev_we) same++;
                prev_we = ram_we;
                have_prev = 1'b1;
            end
            if (bus.in_valid && bus.in_ready) n++;
            k++;
        end
        check("stream_pushed", 32'(n), 32'd16);
        drain();
        check("stream_alternate", 32'(same), 32'd0);
        check("stream_pops", 32'(pops - pop0), 32'd16);

        // Full boundary: 8 in RAM + 2 in obuf
        push_n(10, 1'b0, 8'h40);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h4A, 1'b0, 1'b0);
            check("full_in_ready", 32'(bus.in_ready), 32'd0);
        end
        check("full_level", 32'(level), 32'd10);
        check("full_head", 32'(bus.out_data), 32'h40);
        cyc(1'b1, 8'h4A, 1'b1, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 8'h4A, 1'b0, 1'b0);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("full_ready_return", 32'(got), 32'd1);
        drain();

        // Random stream, 40 bytes, pointers wrap several times
        n = 0; k = 0;
        while (n < 40 && k < 1000) begin
            cyc(1'($urandom % 2), DW'($urandom), 1'($urandom % 2), 1'b0);
            if (bus.in_valid && bus.in_ready) n++;
            k++;
        end
        check("rand_pushed", 32'(n), 32'd40);
        drain();

        // Flush with a read in flight at level 5
        push_n(5, 1'b0, 8'h60);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("flush_pre_level", 32'(level), 32'd5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("flush_rd_grant", 32'({ram_ce, ram_we}), 32'b10);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd0);
        check("flush_ram_ce", 32'(ram_ce), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_flush_level", 32'(level), 32'd0);
        check("post_flush_valid", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_flush_head", 32'(bus.out_data), 32'h3C);
        drain();

        // Asynchronous reset mid-stream
        push_n(6, 1'b0, 8'h80);
        check("prereset_level_nz", 32'(level != 0), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_ram_ce", 32'(ram_ce), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        push_n(4, 1'b1, 8'hC0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spram_fifo.md
Name: spram_fifo

Overview:
- FIFO controller that owns the single port of the team's generic synchronous single-port RAM (`spram`) and turns it into a streaming byte queue, for example the I2C TX/RX data buffer.
- Upstream side: a push valid/ready stream. Downstream side: a show-ahead pop valid/ready stream.
- One RAM access per cycle, arbitrated between write and read.
- A 2-entry output buffer hides the RAM's 1-cycle read latency.
- The RAM is instantiated by the parent and wired to the ram_* ports.

Parameters:
AW  10  RAM address bits; RAM depth DEPTH = 1<<AW
DW  8   data width, matching the RAM dw

Ports:
clk        in   1     clock, rising edge
rst_n      in   1     asynchronous active-low reset
flush      in   1     synchronous clear of all contents
in_valid   in   1     push request
in_ready   out  1     push accepted when in_valid && in_ready
in_data    in   DW    push data
out_valid  out  1     head of queue valid
out_ready  in   1     pop when out_valid && out_ready
out_data   out  DW    head data, stable while out_valid && !out_ready
level      out  AW+1  total entries held (RAM + in-flight read + output buffer)
ram_ce     out  1     RAM chip enable
ram_we     out  1     RAM write enable
ram_oe     out  1     RAM output enable
ram_addr   out  AW    RAM address
ram_di     out  DW    RAM write data
ram_do     in   DW    RAM read data, valid the cycle after a read access

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ptr=rd_ptr=0, ram_cnt=0, inflight=0, obuf empty, last_grant=READ.
  - Outputs: out_valid=0, in_ready=0 while in reset, level=0, ram_ce/we/oe=0.
- Internal state:
  - wr_ptr, rd_ptr: AW bits each, wrap modulo DEPTH.
  - ram_cnt: AW+1 bits, range 0..DEPTH.
  - inflight: 1 bit.
  - obuf: 2-entry queue with ob_cnt 0..2.
- Request conditions:
  - wr_req = in_valid && ram_cnt != DEPTH.
  - rd_req = ram_cnt != 0 && (ob_cnt + inflight - (out_valid && out_ready)) < 2.
- Arbitration (combinational, per cycle):
  - Only one request: it wins.
  - Both requests: the side opposite last_grant wins.
  - last_grant updates only on a granted cycle.
- in_ready = ram_cnt != DEPTH && !(rd_req && last_grant==WRITE). It does not depend on in_valid.
- Write grant:
  - ram_ce=1, ram_we=1, ram_addr=wr_ptr, ram_di=in_data.
  - wr_ptr++, ram_cnt++.
- Read grant:
  - ram_ce=1, ram_we=0, ram_oe=1, ram_addr=rd_ptr.
  - rd_ptr++, ram_cnt--, inflight<=1.
- Capture: in the cycle with inflight=1, ram_do is pushed into the obuf tail at the clock edge, and inflight clears unless a new read is granted.
- Idle cycle: ram_ce=ram_we=ram_oe=0.
- Output side:
  - out_valid = ob_cnt != 0; out_data = obuf head.
  - Pop and capture in the same cycle are both applied.
- Latency:
  - Push accepted in cycle t into an empty FIFO: read granted at t+1, captured at the end of t+2, out_valid=1 at t+3.
  - Sustained throughput is 1 entry per 2 cycles when both sides are active (single port).
- Full boundary: ram_cnt==DEPTH forces in_ready=0. Data in obuf does not count against DEPTH, so level can reach DEPTH+2.
- Empty boundary: ram_cnt==0 suppresses reads; out_valid drops once obuf drains.
- Pointer wrap: DEPTH-1 -> 0 with no special handling; order is preserved.
- Flush (synchronous, highest priority):
  - Same state as reset, except last_grant is unchanged.
  - No RAM access in the flush cycle.
  - A read in flight during the flush cycle is discarded and not captured.
  - Pushes and pops presented in the flush cycle are ignored; in_ready=0 and out_valid=0 in that cycle.
- Reset asserted mid-operation: immediate clear, no partial write guarantee. RAM contents are don't-care.
- level = ram_cnt + inflight + ob_cnt, registered and updated every cycle.

Decomposition:
- No shared package. localparams DEPTH and GRANT_WR/GRANT_RD stay local.
- Sub-module spram_fifo_obuf: 2-entry show-ahead buffer (push, pop, count, head data) with asynchronous active-low reset and synchronous clear.
- The RAM stays outside. The bench instantiates spram with aw=AW, dw=DW and wires its rst input to 0.

Test Plan:
- Reset, then push 0xA5 at cycle 0 with out_ready=0 -> out_valid rises at cycle 3 with out_data=0xA5; level=1.
- Push 0x00..0x0F back-to-back with out_ready=1 -> pops 0x00..0x0F in order, no drops or duplicates; ram_we and read accesses alternate while both are pending.
- AW=3: push 10 bytes with out_ready=0 -> in_ready=0 after ram_cnt reaches 8 with obuf holding 2, level=10; pop 1 -> in_ready returns within 2 cycles.
- AW=3: stream 40 bytes (pointers wrap 5 times) with random in_valid/out_ready -> output sequence equals input sequence.
- Assert flush in the same cycle as a read grant with level=5 -> next cycle level=0, out_valid=0, no capture of the in-flight data; a following push of 0x3C is popped first.
- Assert rst_n=0 asynchronously mid-stream -> out_valid, level and ram_ce go to 0 without a clock edge; after release the FIFO behaves as empty.
